// File: rtl/acq_sequencer.sv
// Acquisition run controller: consumes parser command bytes, holds the 32-bit
// run duration and sequences the timer/pulse-sequencer enables through a run.
module acq_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned DRAIN_CYCLES  = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  input  logic [7:0] cmd_data,
  output logic       cmd_ack,
  input  logic       samp_lost,
  output logic       timer_reset_counter,
  output logic       timer_operate,
  output logic       seq_operate,
  output logic       running,
  output logic       done,
  output logic       lost_flag,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    ARM   = 3'd2,
    RUN   = 3'd3,
    DRAIN = 3'd4
  } state_t;

  localparam logic [7:0] OP_LOAD     = 8'h40;
  localparam logic [7:0] SETTLE_INIT = 8'(SETTLE_CYCLES);
  localparam logic [7:0] DRAIN_INIT  = 8'(DRAIN_CYCLES);

  state_t      cur;
  state_t      nxt;
  logic [31:0] duration;
  logic [31:0] run_cnt;
  logic [31:0] run_cnt_nxt;
  logic [7:0]  settle_cnt;
  logic [7:0]  settle_nxt;
  logic [7:0]  drain_cnt;
  logic [7:0]  drain_nxt;
  logic [2:0]  load_left;
  logic        consume;
  logic        is_cmd;
  logic        cmd_start;
  logic        cmd_stop;
  logic        cmd_abort;
  logic        done_nxt;
  logic        lost_nxt;

  // A byte is taken only while no ack is outstanding, limiting intake to one
  // byte every two cycles; bytes following LOAD are pure data.
  assign consume   = cmd_valid && !cmd_ack;
  assign is_cmd    = consume && (load_left == 3'd0) && (cmd_data != OP_LOAD);
  assign cmd_abort = is_cmd && cmd_data[2];
  assign cmd_stop  = is_cmd && cmd_data[1] && !cmd_data[2];
  assign cmd_start = is_cmd && cmd_data[0] && !cmd_data[1] && !cmd_data[2];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cmd_ack   <= 1'b0;
      load_left <= '0;
      duration  <= '0;
    end else begin
      cmd_ack <= consume;
      if (consume) begin
        if (load_left != 3'd0) begin
          // LSB first: after four shifts the first byte lands in [7:0].
          duration  <= {cmd_data, duration[31:8]};
          load_left <= load_left - 3'd1;
        end else if (cmd_data == OP_LOAD) begin
          load_left <= 3'd4;
        end
      end
    end
  end

  always_comb begin
    nxt         = cur;
    settle_nxt  = settle_cnt;
    drain_nxt   = drain_cnt;
    run_cnt_nxt = run_cnt;
    done_nxt    = done;
    lost_nxt    = lost_flag;

    if ((cur == RUN || cur == DRAIN) && samp_lost) begin
      lost_nxt = 1'b1;
    end

    unique case (cur)
      IDLE: begin
        if (cmd_start) begin
          nxt      = CLEAR;
          done_nxt = 1'b0;
          lost_nxt = 1'b0;
        end
      end
      CLEAR: begin
        nxt        = ARM;
        settle_nxt = SETTLE_INIT;
      end
      ARM: begin
        if (cmd_stop) begin
          nxt      = IDLE;
          done_nxt = 1'b0;
        end else if (settle_cnt == 8'd1) begin
          nxt         = RUN;
          run_cnt_nxt = duration;
        end else begin
          settle_nxt = settle_cnt - 8'd1;
        end
      end
      RUN: begin
        // A zero count never reaches 1, so a zero duration runs until STOP.
        if (cmd_stop || run_cnt == 32'd1) begin
          nxt       = DRAIN;
          drain_nxt = DRAIN_INIT;
        end else if (run_cnt != '0) begin
          run_cnt_nxt = run_cnt - 32'd1;
        end
      end
      DRAIN: begin
        if (drain_cnt == 8'd1) begin
          nxt      = IDLE;
          done_nxt = 1'b1;
        end else begin
          drain_nxt = drain_cnt - 8'd1;
        end
      end
      default: nxt = IDLE;
    endcase

    if (cmd_abort && cur != IDLE) begin
      nxt      = IDLE;
      done_nxt = 1'b0;
    end
  end

  // Enables are registered from the next state so they align with state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur                 <= IDLE;
      run_cnt             <= '0;
      settle_cnt          <= '0;
      drain_cnt           <= '0;
      done                <= 1'b0;
      lost_flag           <= 1'b0;
      timer_reset_counter <= 1'b0;
      timer_operate       <= 1'b0;
      seq_operate         <= 1'b0;
      running             <= 1'b0;
    end else begin
      cur                 <= nxt;
      run_cnt             <= run_cnt_nxt;
      settle_cnt          <= settle_nxt;
      drain_cnt           <= drain_nxt;
      done                <= done_nxt;
      lost_flag           <= lost_nxt;
      timer_reset_counter <= (nxt == CLEAR);
      timer_operate       <= (nxt == RUN) || (nxt == DRAIN);
      seq_operate         <= (nxt == RUN);
      running             <= (nxt != IDLE);
    end
  end

  assign state = cur;

endmodule
